// File: rtl/serial_twos_negator.sv
// Bit-serial LSB-first two's-complement negator for framed W-bit words.
// Optional overflow flag enabled by defining SERIAL_NEG_OVF_EN.
module serial_twos_negator #(
    parameter int W = 8
) (
    input  logic clk,
    input  logic res,
    input  logic in_bit,
    input  logic in_valid,
    input  logic in_sof,
    input  logic neg,
    output logic out_bit,
    output logic out_valid,
    output logic out_last,
    output logic ovf
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(W - 1);

    typedef enum logic {
        COPY = 1'b0,
        FLIP = 1'b1
    } state_t;

    logic [CW-1:0] cnt_q, cnt_d;
    state_t        state_q, state_d;
    logic          mode_q, mode_d;
    logic          out_bit_q, out_bit_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;

    logic [CW-1:0] idx;
    logic          first;
    logic          last;
    state_t        st;
    logic          md;

    // Bit 0 of a word sees a fresh COPY state and the live neg input.
    always_comb begin
        idx   = in_sof ? '0 : cnt_q;
        first = (idx == '0);
        last  = (idx == LAST_IDX);
        st    = first ? COPY : state_q;
        md    = first ? neg : mode_q;

        cnt_d       = cnt_q;
        state_d     = state_q;
        mode_d      = mode_q;
        out_bit_d   = out_bit_q;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;

        if (in_valid) begin
            cnt_d       = last ? '0 : idx + CW'(1);
            state_d     = (st == COPY && in_bit) ? FLIP : st;
            mode_d      = md;
            out_bit_d   = in_bit ^ (md && st == FLIP);
            out_valid_d = 1'b1;
            out_last_d  = last;
        end
    end

    always_ff @(posedge clk) begin
        if (!res) begin
            cnt_q       <= '0;
            state_q     <= COPY;
            mode_q      <= 1'b0;
            out_bit_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            mode_q      <= mode_d;
            out_bit_q   <= out_bit_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_bit   = out_bit_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

`ifdef SERIAL_NEG_OVF_EN
    logic ovf_q, ovf_d;

    // Still in COPY at the top bit means every lower bit was zero.
    always_comb begin
        ovf_d = in_valid && last && md && (st == COPY) && in_bit;
    end

    always_ff @(posedge clk) begin
        if (!res) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_twos_negator.sv
// Self-checking bench for serial_twos_negator (W=8 and W=5 instances).
// Expected words come from plain modular arithmetic on whole words.
module tb_serial_twos_negator;

    logic clk = 1'b0;
    logic res = 1'b0;
    logic in_bit = 1'b0;
    logic in_valid = 1'b0;
    logic in_sof = 1'b0;
    logic neg = 1'b0;

    logic o8_bit, o8_valid, o8_last, o8_ovf;
    logic o5_bit, o5_valid, o5_last, o5_ovf;

    int vectors = 0;
    int errors = 0;
    logic held8 = 1'b0;
    logic held5 = 1'b0;

    always #5 clk = ~clk;

    serial_twos_negator #(.W(8)) u8 (
        .clk(clk), .res(res), .in_bit(in_bit), .in_valid(in_valid),
        .in_sof(in_sof), .neg(neg), .out_bit(o8_bit),
        .out_valid(o8_valid), .out_last(o8_last), .ovf(o8_ovf)
    );

    serial_twos_negator #(.W(5)) u5 (
        .clk(clk), .res(res), .in_bit(in_bit), .in_valid(in_valid),
        .in_sof(in_sof), .neg(neg), .out_bit(o5_bit),
        .out_valid(o5_valid), .out_last(o5_last), .ovf(o5_ovf)
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic s,
                         input logic b, input logic n);
        @(negedge clk);
        res = r;
        in_valid = v;
        in_sof = s;
        in_bit = b;
        neg = n;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        check("rst8_bit", o8_bit, 1'b0);
        check("rst8_valid", o8_valid, 1'b0);
        check("rst8_last", o8_last, 1'b0);
        check("rst8_ovf", o8_ovf, 1'b0);
        check("rst5_bit", o5_bit, 1'b0);
        check("rst5_valid", o5_valid, 1'b0);
        check("rst5_last", o5_last, 1'b0);
        check("rst5_ovf", o5_ovf, 1'b0);
        held8 = 1'b0;
        held5 = 1'b0;
    endtask

    // Send bit i of word x for the width-w instance and check it.
    task automatic tx_bit(input int w, input logic [63:0] x, input logic n,
                          input int i, input logic sof);
        logic [63:0] mask;
        logic [63:0] ew;
        logic eb, eo, ob, ov, ol, oo;
        mask = (64'd1 << w) - 64'd1;
        ew = (n ? (~x + 64'd1) : x) & mask;
        eb = ew[i];
`ifdef SERIAL_NEG_OVF_EN
        eo = (i == w - 1) && n && ((x & mask) == (64'd1 << (w - 1)));
`else
        eo = 1'b0;
`endif
        drive(1'b1, 1'b1, sof, x[i], n);
        ob = (w == 5) ? o5_bit : o8_bit;
        ov = (w == 5) ? o5_valid : o8_valid;
        ol = (w == 5) ? o5_last : o8_last;
        oo = (w == 5) ? o5_ovf : o8_ovf;
        check($sformatf("bit w%0d x%0h i%0d", w, x, i), ob, eb);
        check($sformatf("valid w%0d i%0d", w, i), ov, 1'b1);
        check($sformatf("last w%0d i%0d", w, i), ol, i == w - 1);
        check($sformatf("ovf w%0d x%0h i%0d", w, x, i), oo, eo);
        if (w == 5) held5 = eb;
        else held8 = eb;
    endtask

    task automatic tx_word(input int w, input logic [63:0] x, input logic n,
                           input logic sof);
        for (int i = 0; i < w; i++) tx_bit(w, x, n, i, sof && i == 0);
    endtask

    // Idle cycle with junk on in_bit/in_sof; output must hold.
    task automatic stall(input int w, input logic s, input logic b);
        drive(1'b1, 1'b0, s, b, ~neg);
        if (w == 5) begin
            check("stall5_valid", o5_valid, 1'b0);
            check("stall5_hold", o5_bit, held5);
            check("stall5_last", o5_last, 1'b0);
        end else begin
            check("stall8_valid", o8_valid, 1'b0);
            check("stall8_hold", o8_bit, held8);
            check("stall8_last", o8_last, 1'b0);
        end
    endtask

    initial begin
        logic [7:0] x;
        logic n;

        do_reset();
        do_reset();

        tx_word(8, 64'h06, 1'b1, 1'b1);

        tx_word(8, 64'h06, 1'b0, 1'b1);
        tx_word(8, 64'h01, 1'b1, 1'b0);

        tx_word(8, 64'h80, 1'b1, 1'b1);
        tx_word(8, 64'h00, 1'b1, 1'b0);

        for (int i = 0; i < 3; i++) tx_bit(8, 64'h0C, 1'b1, i, i == 0);
        for (int k = 0; k < 3; k++) stall(8, 1'b1, 1'b1);
        for (int i = 3; i < 8; i++) tx_bit(8, 64'h0C, 1'b1, i, 1'b0);

        for (int i = 0; i < 5; i++) tx_bit(8, 64'h30, 1'b1, i, i == 0);
        tx_word(8, 64'h02, 1'b1, 1'b1);

        for (int i = 0; i < 7; i++) tx_bit(8, 64'h55, 1'b0, i, i == 0);
        tx_word(8, 64'h0F, 1'b1, 1'b1);

        for (int k = 0; k < 24; k++) begin
            x = 8'($urandom);
            if (k == 3) x = 8'h80;
            n = 1'($urandom_range(0, 1));
            for (int i = 0; i < 8; i++) begin
                tx_bit(8, {56'd0, x}, n, i,
                       i == 0 && $urandom_range(0, 1) == 1);
                if ($urandom_range(0, 3) == 0)
                    stall(8, 1'($urandom), 1'($urandom));
            end
        end

        do_reset();
        for (int i = 0; i < 3; i++) tx_bit(5, 64'h0B, 1'b0, i, i == 0);
        do_reset();
        tx_word(5, 64'h03, 1'b1, 1'b0);
        tx_word(5, 64'h10, 1'b1, 1'b0);

        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/serial_twos_negator.md
# serial_twos_negator

Bit-serial, LSB-first two's-complement negator for framed W-bit words. Each word is either negated or passed through, selected per word. It replaces the single-stream, unframed complementer in the serial arithmetic datapath: it adds a word counter, a valid qualifier, resynchronisation, and an optional overflow flag. It sits between the serial operand shifters and the bit-serial adder.

## Interface
Parameters:
- `W`, default 8: word length in bits; legal range 2..64.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `res` input 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `in_bit` input 1: serial data, LSB first.
- `in_valid` input 1: `in_bit` is meaningful this cycle; low = stall.
- `in_sof` input 1: start of frame; when high with `in_valid`, this bit is bit 0 of a new word.
- `neg` input 1: 1 = negate the word, 0 = pass it through; sampled only on bit 0 of a word.
- `out_bit` output 1: serial result, LSB first.
- `out_valid` output 1: `out_bit` is meaningful.
- `out_last` output 1: `out_bit` is bit W-1 of a word.
- `ovf` output 1: negation overflow; see Configuration.

## Operation
- Bit counter `cnt`, width $clog2(W), counts accepted bits 0..W-1 and wraps to 0 after W-1.
- A bit is accepted when `in_valid`=1. With `in_sof`=1 the accepted bit is treated as `cnt`=0, whatever the current count.
- On bit 0, `neg` is latched into `mode` for the whole word.
- Per-word FSM, cleared on bit 0 of every word:
  - COPY: output = input. On input 1, go to FLIP. The 1 itself is output unflipped.
  - FLIP: output = ~input. Stay in FLIP until the word ends.
- When `mode`=0, the FSM is ignored and output = input.
- Bit 0 is evaluated in COPY regardless of the previous word's end state.
- A mid-word `in_sof` abandons the current word: no `out_last` is issued for it, and `cnt`, FSM and `mode` restart from the new bit.
- Stall (`in_valid`=0): `cnt`, FSM and `mode` hold; `out_valid`=0; `out_bit` holds its last value.
- The input `in_sof` signal is ignored when `in_valid`=0.

## Timing
- Latency: 1 cycle. The input accepted at edge k appears on `out_bit`/`out_valid`/`out_last` after edge k.
- Throughput: 1 bit/cycle with no back-pressure. The downstream block must accept every valid bit.
- `out_last`=1 exactly when the accepted bit had `cnt`=W-1.
- Reset (`res`=0 at an edge) clears:
  - `cnt`=0, FSM=COPY, `mode`=0.
  - All outputs: `out_bit`=0, `out_valid`=0, `out_last`=0, `ovf`=0.
- Reset has priority over `in_valid`.
- Reset mid-word discards the partial word. The next accepted bit is bit 0, with or without `in_sof`.
- Wrap: after `cnt`=W-1, the next accepted bit starts a new word (`cnt`=0, FSM=COPY, `neg` sampled), even without `in_sof`.
- Simultaneous `in_sof` and `cnt`=W-1 expected: `in_sof` wins. The bit is bit 0, and the previous word gets no `out_last`.

## Configuration
- Macro `SERIAL_NEG_OVF_EN`.
- Defined: `ovf` pulses high together with `out_last` when `mode`=1, bits 0..W-2 were all 0, and bit W-1 is 1. This is the most-negative input, whose negation is not representable; the output word equals the input word. `ovf` is 0 in all other cycles.
- Not defined: `ovf` is tied to 0, and no overflow logic is synthesised.

## Test plan
- W=8, `neg`=1, 0x06 sent LSB-first with `in_sof` on bit 0 -> output 0xFA, `out_last` on the 8th output bit, `ovf`=0.
- W=8, `neg`=0, 0x06 followed back-to-back by `neg`=1, 0x01 -> outputs 0x06 then 0xFF. The FSM restarts in COPY for the second word.
- W=8, `neg`=1, 0x80 and then 0x00 -> outputs 0x80 with `ovf`=1 (macro defined) or `ovf`=0 (undefined), then 0x00 with `ovf`=0.
- W=8, `neg`=1, 0x0C with `in_valid` low for 3 cycles after bit 2 -> output 0xF4. `out_valid` is low for exactly 3 cycles, and `out_bit` holds during the stall.
- W=8, `neg`=1, 0x30 interrupted after bit 4 by `in_sof` with a new word 0x02 -> no `out_last` for the first word; second output is 0xFE.
- W=5, `res`=0 for one edge mid-word during 0x0B, then 0x03 with `neg`=1 -> all outputs 0 after the reset edge; next word outputs 0x1D with `out_last` on its 5th bit.
